calendar_day_month: RTL and testbench

CALENDAR_DAY_MONTH -- requirements
Module: calendar_day_month

---
 rtl/calendar_pkg.sv | 25 ++
 rtl/month_len_lut.sv | 40 ++++
 rtl/calendar_day_month.sv | 91 +++++++++
 tb/tb_calendar_day_month.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/calendar_pkg.sv
// Shared constants for the day/month calendar counter.
package calendar_pkg;

    localparam int DAY_W   = 5;
    localparam int MONTH_W = 4;

    localparam logic [MONTH_W-1:0] JAN = 4'd1;
    localparam logic [MONTH_W-1:0] FEB = 4'd2;
    localparam logic [MONTH_W-1:0] MAR = 4'd3;
    localparam logic [MONTH_W-1:0] APR = 4'd4;
    localparam logic [MONTH_W-1:0] MAY = 4'd5;
    localparam logic [MONTH_W-1:0] JUN = 4'd6;
    localparam logic [MONTH_W-1:0] JUL = 4'd7;
    localparam logic [MONTH_W-1:0] AUG = 4'd8;
    localparam logic [MONTH_W-1:0] SEP = 4'd9;
    localparam logic [MONTH_W-1:0] OCT = 4'd10;
    localparam logic [MONTH_W-1:0] NOV = 4'd11;
    localparam logic [MONTH_W-1:0] DEC = 4'd12;

    localparam logic [DAY_W-1:0] DAYS_28 = 5'd28;
    localparam logic [DAY_W-1:0] DAYS_29 = 5'd29;
    localparam logic [DAY_W-1:0] DAYS_30 = 5'd30;
    localparam logic [DAY_W-1:0] DAYS_31 = 5'd31;

endpackage

// File: rtl/month_len_lut.sv
// Combinational month-length decode. Leap-year February is enabled by
// defining CALENDAR_LEAP_YEAR_EN; otherwise February is always 28 days.
module month_len_lut
    import calendar_pkg::*;
#(
    parameter int YEAR_WIDTH = 12
) (
    input  logic [MONTH_W-1:0]    month,
    input  logic [YEAR_WIDTH-1:0] year,
    output logic [DAY_W-1:0]      days
);

    logic is_leap;

`ifdef CALENDAR_LEAP_YEAR_EN
    int unsigned year_ext;

    always_comb begin
        year_ext = 32'(year);
        is_leap  = ((year_ext % 4) == 0 && (year_ext % 100) != 0) || ((year_ext % 400) == 0);
    end
`else
    logic unused_year;

    assign unused_year = ^year;
    assign is_leap     = 1'b0;
`endif

    // Out-of-range months decode to 0 so no day can ever be valid for them.
    always_comb begin
        days = '0;
        case (month)
            JAN, MAR, MAY, JUL, AUG, OCT, DEC: days = DAYS_31;
            APR, JUN, SEP, NOV:                days = DAYS_30;
            FEB:                               days = is_leap ? DAYS_29 : DAYS_28;
            default:                           days = '0;
        endcase
    end

endmodule

// File: rtl/calendar_day_month.sv
// Day/month calendar counter with date load and year-advance tick.
// Leap-year support via CALENDAR_LEAP_YEAR_EN (see month_len_lut).
module calendar_day_month
    import calendar_pkg::*;
#(
    parameter int YEAR_WIDTH = 12
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_cnt_en,
    input  logic [YEAR_WIDTH-1:0] i_year,
    input  logic                  i_load,
    input  logic [4:0]            i_load_day,
    input  logic [3:0]            i_load_month,
    output logic [4:0]            o_day,
    output logic [3:0]            o_month,
    output logic                  o_tick,
    output logic                  o_load_err
);

    logic [DAY_W-1:0]   day_q, day_d;
    logic [MONTH_W-1:0] month_q, month_d;
    logic               tick_q, tick_d;
    logic               load_err_q, load_err_d;

    logic [DAY_W-1:0]   cur_len;
    logic [DAY_W-1:0]   load_len;
    logic               load_valid;

    month_len_lut #(.YEAR_WIDTH(YEAR_WIDTH)) u_cur_len (
        .month (month_q),
        .year  (i_year),
        .days  (cur_len)
    );

    month_len_lut #(.YEAR_WIDTH(YEAR_WIDTH)) u_load_len (
        .month (i_load_month),
        .year  (i_year),
        .days  (load_len)
    );

    assign load_valid = (i_load_day != '0) && (i_load_day <= load_len);

    always_comb begin
        day_d      = day_q;
        month_d    = month_q;
        tick_d     = 1'b0;
        load_err_d = 1'b0;
        if (i_load) begin
            if (load_valid) begin
                day_d   = i_load_day;
                month_d = i_load_month;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (i_cnt_en) begin
            // >= also recovers a 29 Feb left stale by a year change.
            if (day_q >= cur_len) begin
                day_d = 5'd1;
                if (month_q >= DEC) begin
                    month_d = JAN;
                    tick_d  = 1'b1;
                end else begin
                    month_d = month_q + 4'd1;
                end
            end else begin
                day_d = day_q + 5'd1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            day_q      <= 5'd1;
            month_q    <= JAN;
            tick_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            day_q      <= day_d;
            month_q    <= month_d;
            tick_q     <= tick_d;
            load_err_q <= load_err_d;
        end
    end

    assign o_day      = day_q;
    assign o_month    = month_q;
    assign o_tick     = tick_q;
    assign o_load_err = load_err_q;

endmodule

// File: tb/tb_calendar_day_month.sv
// Directed self-checking bench for calendar_day_month.
module tb_calendar_day_month;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic        i_cnt_en = 1'b0;
    logic [11:0] i_year = 12'd2023;
    logic        i_load = 1'b0;
    logic [4:0]  i_load_day = 5'd1;
    logic [3:0]  i_load_month = 4'd1;
    logic [4:0]  o_day;
    logic [3:0]  o_month;
    logic        o_tick;
    logic        o_load_err;

    int n_checks = 0;
    int n_errors = 0;

    calendar_day_month #(.YEAR_WIDTH(12)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_cnt_en     (i_cnt_en),
        .i_year       (i_year),
        .i_load       (i_load),
        .i_load_day   (i_load_day),
        .i_load_month (i_load_month),
        .o_day        (o_day),
        .o_month      (o_month),
        .o_tick       (o_tick),
        .o_load_err   (o_load_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check_date(input string tag, input int d, input int m, input int tick, input int err);
        check({tag, " day"}, int'(o_day), d);
        check({tag, " month"}, int'(o_month), m);
        check({tag, " tick"}, int'(o_tick), tick);
        check({tag, " err"}, int'(o_load_err), err);
    endtask

    task automatic load_date(input int d, input int m, input logic cnt);
        i_load       = 1'b1;
        i_load_day   = 5'(d);
        i_load_month = 4'(m);
        i_cnt_en     = cnt;
        step();
        i_load   = 1'b0;
        i_cnt_en = 1'b0;
    endtask

    task automatic count();
        i_cnt_en = 1'b1;
        step();
        i_cnt_en = 1'b0;
    endtask

    initial begin
        // Dirty the state first so reset values are meaningful.
        load_date(15, 7, 1'b0);
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        check_date("reset", 1, 1, 0, 0);

        load_date(31, 1, 1'b0);
        check_date("load 31/1", 31, 1, 0, 0);
        count();
        check_date("31/1 +1", 1, 2, 0, 0);

        load_date(30, 4, 1'b0);
        count();
        check_date("30/4 +1", 1, 5, 0, 0);
        step();
        check_date("hold", 1, 5, 0, 0);

        load_date(15, 6, 1'b0);
        count();
        check_date("15/6 +1", 16, 6, 0, 0);

        load_date(30, 11, 1'b0);
        count();
        check_date("30/11 +1", 1, 12, 0, 0);

        i_year = 12'd2024;
        load_date(28, 2, 1'b0);
        count();
`ifdef CALENDAR_LEAP_YEAR_EN
        check_date("2024 28/2 +1", 29, 2, 0, 0);
        count();
        check_date("2024 29/2 +1", 1, 3, 0, 0);
        i_year = 12'd1900;
        load_date(28, 2, 1'b0);
        count();
        check_date("1900 28/2 +1", 1, 3, 0, 0);
        i_year = 12'd2000;
        load_date(28, 2, 1'b0);
        count();
        check_date("2000 28/2 +1", 29, 2, 0, 0);
`else
        check_date("2024 28/2 +1 noleap", 1, 3, 0, 0);
        load_date(29, 2, 1'b0);
        check_date("2024 load 29/2 noleap", 1, 3, 0, 1);
`endif

        i_year = 12'd2023;
        load_date(10, 3, 1'b0);
        load_date(29, 2, 1'b0);
        check_date("2023 load 29/2", 10, 3, 0, 1);

        load_date(31, 12, 1'b0);
        check_date("load 31/12 no tick", 31, 12, 0, 0);
        count();
        check_date("rollover", 1, 1, 1, 0);
        step();
        check_date("after rollover", 1, 1, 0, 0);

        load_date(20, 8, 1'b0);
        load_date(31, 4, 1'b0);
        check_date("bad 31/4", 20, 8, 0, 1);
        step();
        check_date("err clears", 20, 8, 0, 0);

        load_date(0, 5, 1'b1);
        check_date("bad 0/5 with cnt", 20, 8, 0, 1);
        load_date(1, 13, 1'b0);
        check_date("bad 1/13", 20, 8, 0, 1);

        load_date(15, 6, 1'b1);
        check_date("load beats cnt", 15, 6, 0, 0);

        i_rst = 1'b1;
        load_date(31, 12, 1'b0);
        i_rst = 1'b0;
        check_date("rst beats load", 1, 1, 0, 0);

        load_date(31, 12, 1'b0);
        i_rst = 1'b1;
        count();
        i_rst = 1'b0;
        check_date("rst at rollover", 1, 1, 0, 0);
        step();
        check_date("no tick after rst", 1, 1, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
